axil_cmd_master: RTL and testbench

AXI-Lite write master that sits directly upstream of the peripheral register slaves (LED controller and siblings) on the AXI_LITE bus. It accepts 32-bit address/data write commands from the packet-parsing logic over a valid/ready port, buffers them in a small FIFO, and issues one AXI-Lite write transaction per command. Completion status (OKAY, slave error, or timeout) is reported per command on a response strobe.

---
 rtl/axil_pkg.sv | 25 ++
 rtl/axil_if.sv | 40 ++++
 rtl/sync_fifo.sv | 70 +++++++
 rtl/axil_cmd_master.sv | 174 +++++++++++++++++
 tb/tb_axil_cmd_master.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axil_pkg.sv
// Shared types for the AXI-Lite command master: response codes, write FSM
// states and the command record carried through the command FIFO.
// No logic; imported by the master and its testbench-facing interface users.
package axil_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'd0,
    EXOKAY = 2'd1,
    SLVERR = 2'd2,
    DECERR = 2'd3
  } axil_resp_e;

  typedef enum logic [1:0] {
    IDLE,
    ADDR,
    DATA,
    RESP
  } axil_wr_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } axil_cmd_t;

endpackage

// File: rtl/axil_if.sv
// AXI-Lite bundle (32-bit address and data) shared by the command master and
// the peripheral register slaves. No logic; master and slave views only.
interface AXI_LITE;
  logic [31:0] awaddr;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [31:0] araddr;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;

  modport master (
    output awaddr, awprot, awvalid, input awready,
    output wdata, wstrb, wlast, wvalid, input wready,
    input  bresp, bvalid, output bready,
    output araddr, arprot, arvalid, input arready,
    input  rdata, rresp, rvalid, output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid, output awready,
    input  wdata, wstrb, wlast, wvalid, output wready,
    output bresp, bvalid, input bready,
    input  araddr, arprot, arvalid, output arready,
    output rdata, rresp, rvalid, input rready
  );
endinterface

// File: rtl/sync_fifo.sv
// Purpose: single-clock FIFO with registered full/empty flags and occupancy.
// Latency: a push is visible on empty/rd_data the cycle after it is written.
// Backpressure: pushes while full and pops while empty are ignored.
// Ports: aclk/aresetn; push + wr_data; pop; rd_data (head, show-ahead);
//        full, empty, count (0..DEPTH).
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rd_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             empty_q, empty_d;
  logic             push_ok, pop_ok;

  assign push_ok = push && !full_q;
  assign pop_ok  = pop && !empty_q;

  // Pointers are exactly AW bits wide, so wrap modulo DEPTH is free.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge aclk) begin
    if (push_ok) mem_q[wr_ptr_q] <= wr_data;
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign full    = full_q;
  assign empty   = empty_q;
  assign count   = count_q;
endmodule

// File: rtl/axil_cmd_master.sv
// Purpose: queues addr/data write commands and issues one AXI-Lite write each.
// Latency: push at N -> awvalid at N+2; zero-wait slave -> rsp_valid 3 cycles later.
// Backpressure: cmd_ready is the registered not-full flag of the command FIFO.
// Ports: aclk/aresetn; cmd_valid/cmd_ready/cmd_addr/cmd_data command input;
//        rsp_valid/rsp_err/rsp_timeout completion strobe; busy; m_axi write master.
module axil_cmd_master
  import axil_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 256
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic        rsp_timeout,
  output logic        busy,
  AXI_LITE.master     m_axi
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned TW = $clog2(TIMEOUT);

  axil_cmd_t                    cmd_in, cmd_head;
  logic [$bits(axil_cmd_t)-1:0] fifo_rd_data;
  logic                         fifo_full, fifo_empty;
  logic [CW-1:0]                fifo_count, count_nxt;
  logic                         push, pop;

  axil_wr_state_e state_q, state_d;
  logic [TW-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic [31:0]    awaddr_q, awaddr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic           awvalid_q, awvalid_d;
  logic           wvalid_q, wvalid_d;
  logic           bready_q, bready_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_err_q, rsp_err_d;
  logic           rsp_timeout_q, rsp_timeout_d;
  logic           busy_q, busy_d;
  logic           phase_hs, tmo_hit;

  assign cmd_in.addr = cmd_addr;
  assign cmd_in.data = cmd_data;
  assign cmd_ready   = !fifo_full;
  assign push        = cmd_valid && cmd_ready;
  assign cmd_head    = fifo_rd_data;

  sync_fifo #(
    .WIDTH ($bits(axil_cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .aclk    (aclk),
    .aresetn (aresetn),
    .push    (push),
    .wr_data (cmd_in),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_d       = state_q;
    pop           = 1'b0;
    awaddr_d      = awaddr_q;
    wdata_d       = wdata_q;
    rsp_valid_d   = 1'b0;
    rsp_err_d     = 1'b0;
    rsp_timeout_d = 1'b0;
    phase_hs      = 1'b0;
    tmo_hit       = (tmo_cnt_q == TW'(TIMEOUT - 1));

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop      = 1'b1;
          awaddr_d = cmd_head.addr;
          wdata_d  = cmd_head.data;
          state_d  = ADDR;
        end
      end
      ADDR: begin
        phase_hs = awvalid_q && m_axi.awready;
        if (phase_hs) state_d = DATA;
      end
      // wvalid only rises after the address handshake: slaves rely on it.
      DATA: begin
        phase_hs = wvalid_q && m_axi.wready;
        if (phase_hs) state_d = RESP;
      end
      RESP: begin
        phase_hs = bready_q && m_axi.bvalid;
        if (phase_hs) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b1;
          rsp_err_d   = (axil_resp_e'(m_axi.bresp) != OKAY);
        end
      end
      default: state_d = IDLE;
    endcase

    // A slave that ignores an unmapped address never handshakes; give up
    // after TIMEOUT cycles in any one phase and report it.
    if (state_q != IDLE && !phase_hs && tmo_hit) begin
      state_d       = IDLE;
      rsp_valid_d   = 1'b1;
      rsp_err_d     = 1'b1;
      rsp_timeout_d = 1'b1;
    end

    tmo_cnt_d = (state_d != state_q || state_q == IDLE) ? '0 : tmo_cnt_q + 1'b1;

    // Channel controls are flops loaded from the next state, so nothing on
    // the AXI inputs reaches an AXI output combinationally.
    awvalid_d = (state_d == ADDR);
    wvalid_d  = (state_d == DATA);
    bready_d  = (state_d == RESP);

    count_nxt = fifo_count + CW'(push) - CW'(pop);
    busy_d    = (count_nxt != '0) || (state_d != IDLE);
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q       <= IDLE;
      tmo_cnt_q     <= '0;
      awaddr_q      <= '0;
      wdata_q       <= '0;
      awvalid_q     <= 1'b0;
      wvalid_q      <= 1'b0;
      bready_q      <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      tmo_cnt_q     <= tmo_cnt_d;
      awaddr_q      <= awaddr_d;
      wdata_q       <= wdata_d;
      awvalid_q     <= awvalid_d;
      wvalid_q      <= wvalid_d;
      bready_q      <= bready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      busy_q        <= busy_d;
    end
  end

  assign rsp_valid   = rsp_valid_q;
  assign rsp_err     = rsp_err_q;
  assign rsp_timeout = rsp_timeout_q;
  assign busy        = busy_q;

  assign m_axi.awaddr  = awaddr_q;
  assign m_axi.awprot  = 3'b000;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = 4'hF;
  assign m_axi.wlast   = 1'b1;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  // Write-only master: read channels held inactive.
  assign m_axi.araddr  = '0;
  assign m_axi.arprot  = 3'b000;
  assign m_axi.arvalid = 1'b0;
  assign m_axi.rready  = 1'b0;
endmodule

// File: tb/tb_axil_cmd_master.sv
module tb_axil_cmd_master;
  localparam int DEPTH = 4;
  localparam int TMO   = 16;
  localparam logic [31:0] LED_CTRL = 32'h4000_0000;

  logic        aclk, aresetn;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_data;
  logic        rsp_valid, rsp_err, rsp_timeout, busy;

  AXI_LITE m_axi();

  axil_cmd_master #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .busy(busy), .m_axi(m_axi)
  );

  initial begin aclk = 1'b0; forever #5 aclk = ~aclk; end

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- slave model ----------------
  int          s_aw_dly, s_w_dly, s_b_dly;
  logic [1:0]  s_bresp;
  logic        s_stray;
  int          aw_cnt, w_cnt, b_cnt;
  logic [7:0]  led;
  logic [31:0] log_a[$], log_d[$];

  task automatic cfg(input int aw, input int w, input int b, input logic [1:0] br, input logic stray);
    s_aw_dly = aw; s_w_dly = w; s_b_dly = b; s_bresp = br; s_stray = stray;
  endtask

  initial begin
    aw_cnt = 0; w_cnt = 0; b_cnt = 0; led = 8'h00;
    m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bresp = 2'b00;
    m_axi.arready = 0; m_axi.rdata = '0; m_axi.rresp = 2'b00; m_axi.rvalid = 0;
    forever begin
      @(posedge aclk); #1;
      if (!aresetn) begin
        m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0;
      end else begin
        m_axi.awready = m_axi.awvalid && (aw_cnt >= s_aw_dly);
        aw_cnt = m_axi.awvalid ? aw_cnt + 1 : 0;
        m_axi.wready = s_stray || (m_axi.wvalid && (w_cnt >= s_w_dly));
        w_cnt = m_axi.wvalid ? w_cnt + 1 : 0;
        m_axi.bvalid = s_stray || (m_axi.bready && (b_cnt >= s_b_dly));
        b_cnt = m_axi.bready ? b_cnt + 1 : 0;
        m_axi.bresp = s_bresp;
        if (m_axi.wvalid && m_axi.wready) begin
          log_a.push_back(m_axi.awaddr);
          log_d.push_back(m_axi.wdata);
          if (m_axi.awaddr == LED_CTRL) led = m_axi.wdata[7:0];
        end
      end
    end
  end

  // ---------------- behavioural model + compare ----------------
  // mq: commands accepted but not yet started. ph: which handshake the
  // master is waiting on (0 none, 1 aw, 2 w, 3 b); pc: cycles spent on it.
  logic [63:0] mq[$];
  int          ph = 0, pc = 0;
  logic [31:0] m_awaddr = '0, m_wdata = '0;
  logic        m_rsp = 0, m_err = 0, m_tmo = 0;
  logic        aw_prev = 0;
  int          aw_rise_cyc = 0, aw_hi = 0, rsp_cyc = 0, rsp_cnt = 0;
  logic        last_err = 0, last_tmo = 0;

  always @(negedge aclk) begin
    logic        acc, hs, n_rsp, n_err, n_tmo;
    logic [63:0] c;
    if (!aresetn) begin
      mq.delete(); ph = 0; pc = 0; m_awaddr = '0; m_wdata = '0;
      m_rsp = 0; m_err = 0; m_tmo = 0; aw_prev = 0;
      chk("rst_cmd_ready", cmd_ready, 1);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_err", rsp_err, 0);
      chk("rst_rsp_timeout", rsp_timeout, 0);
      chk("rst_busy", busy, 0);
      chk("rst_awvalid", m_axi.awvalid, 0);
      chk("rst_wvalid", m_axi.wvalid, 0);
      chk("rst_bready", m_axi.bready, 0);
      chk("rst_awaddr", m_axi.awaddr, 0);
      chk("rst_wdata", m_axi.wdata, 0);
    end else begin
      chk("cmd_ready", cmd_ready, mq.size() < DEPTH);
      chk("busy", busy, (mq.size() != 0) || (ph != 0));
      chk("awvalid", m_axi.awvalid, ph == 1);
      chk("wvalid", m_axi.wvalid, ph == 2);
      chk("bready", m_axi.bready, ph == 3);
      chk("awaddr", m_axi.awaddr, m_awaddr);
      chk("wdata", m_axi.wdata, m_wdata);
      chk("rsp_valid", rsp_valid, m_rsp);
      if (m_rsp) begin
        chk("rsp_err", rsp_err, m_err);
        chk("rsp_timeout", rsp_timeout, m_tmo);
      end
      if (m_axi.wvalid) begin
        chk("wstrb", m_axi.wstrb, 4'hF);
        chk("wlast", m_axi.wlast, 1);
      end
      chk("arvalid", m_axi.arvalid, 0);
      chk("rready", m_axi.rready, 0);

      if (m_axi.awvalid && !aw_prev) aw_rise_cyc = cyc;
      aw_prev = m_axi.awvalid;
      if (m_axi.awvalid) aw_hi++;
      if (rsp_valid) begin
        rsp_cnt++; rsp_cyc = cyc; last_err = rsp_err; last_tmo = rsp_timeout;
      end

      // what the coming edge does
      acc = cmd_valid && (mq.size() < DEPTH);
      n_rsp = 0; n_err = 0; n_tmo = 0;
      if (ph == 0) begin
        if (mq.size() > 0) begin
          c = mq.pop_front();
          m_awaddr = c[63:32]; m_wdata = c[31:0];
          ph = 1; pc = 0;
        end
      end else begin
        hs = (ph == 1) ? m_axi.awready : (ph == 2) ? m_axi.wready : m_axi.bvalid;
        if (hs) begin
          if (ph == 3) begin
            n_rsp = 1; n_err = (m_axi.bresp != 2'b00);
            ph = 0;
          end else begin
            ph = ph + 1;
          end
          pc = 0;
        end else if (pc == TMO - 1) begin
          n_rsp = 1; n_err = 1; n_tmo = 1; ph = 0; pc = 0;
        end else begin
          pc++;
        end
      end
      if (acc) mq.push_back({cmd_addr, cmd_data});
      m_rsp = n_rsp; m_err = n_err; m_tmo = n_tmo;
    end
  end

  // ---------------- stimulus helpers ----------------
  int acc_cyc;

  // Call at posedge+#1; returns at posedge+#1 of the cycle after acceptance.
  task automatic push(input logic [31:0] a, input logic [31:0] d);
    int n = 0;
    cmd_valid = 1; cmd_addr = a; cmd_data = d;
    forever begin
      @(negedge aclk);
      if (cmd_ready) begin acc_cyc = cyc; break; end
      n++;
      if (n > 300) begin
        checks++; fails++;
        $display("FAIL push_timeout: cmd_ready stuck at 0, expected 1 within 300 cycles");
        break;
      end
    end
    @(posedge aclk); #1;
    cmd_valid = 0;
  endtask

  task automatic wait_idle();
    int n = 0;
    forever begin
      @(negedge aclk);
      if (!busy) break;
      n++;
      if (n > 1000) begin
        checks++; fails++;
        $display("FAIL idle_timeout: busy still 1, expected 0 within 1000 cycles");
        break;
      end
    end
    @(posedge aclk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- directed tests ----------------
  int t0, r0, l0;
  logic [31:0] exp_a [5];

  initial begin
    aresetn = 0; cmd_valid = 0; cmd_addr = '0; cmd_data = '0;
    cfg(0, 0, 0, 2'b00, 0);
    repeat (3) @(posedge aclk);
    #3 aresetn = 1;
    @(posedge aclk); #1;

    // 1: single zero-wait write to the LED register
    r0 = rsp_cnt; l0 = log_a.size();
    push(LED_CTRL, 32'h0000_00A5); t0 = acc_cyc;
    wait_idle();
    chk("t1_aw_rise", aw_rise_cyc, t0 + 2);
    chk("t1_rsp_cycle", rsp_cyc, t0 + 5);
    chk("t1_rsp_count", rsp_cnt - r0, 1);
    chk("t1_rsp_err", last_err, 0);
    chk("t1_writes", log_a.size() - l0, 1);
    chk("t1_led", led, 8'hA5);

    // 2: awready after 3 cycles, wready after 2
    cfg(3, 2, 0, 2'b00, 0);
    r0 = rsp_cnt;
    push(32'h4000_0004, 32'h1234_5678); t0 = acc_cyc;
    wait_idle();
    chk("t2_rsp_cycle", rsp_cyc, t0 + 10);
    chk("t2_rsp_count", rsp_cnt - r0, 1);
    chk("t2_wdata_seen", log_d[log_d.size()-1], 32'h1234_5678);

    // 3: five back-to-back commands against a slow slave
    cfg(6, 0, 0, 2'b00, 0);
    r0 = rsp_cnt; l0 = log_a.size();
    for (int i = 0; i < 5; i++) begin
      exp_a[i] = 32'h4000_0100 + 32'(i * 4);
      push(exp_a[i], 32'hC0DE_0000 + 32'(i));
    end
    @(negedge aclk);
    chk("t3_ready_full", cmd_ready, 0);
    @(posedge aclk); #1;
    wait_idle();
    chk("t3_rsp_count", rsp_cnt - r0, 5);
    chk("t3_writes", log_a.size() - l0, 5);
    for (int i = 0; i < 5; i++) begin
      if (l0 + i < log_a.size()) chk("t3_order", log_a[l0 + i], exp_a[i]);
    end

    // 4: unmapped address, slave silent -> timeout, then normal write
    cfg(100000, 0, 0, 2'b00, 0);
    r0 = rsp_cnt; aw_hi = 0;
    push(32'hDEAD_0000, 32'h0000_0001);
    wait_idle();
    chk("t4_aw_cycles", aw_hi, 16);
    chk("t4_rsp_delay", rsp_cyc - aw_rise_cyc, 16);
    chk("t4_rsp_err", last_err, 1);
    chk("t4_rsp_timeout", last_tmo, 1);
    cfg(0, 0, 0, 2'b00, 0);
    push(32'h4000_0008, 32'h0000_0002);
    wait_idle();
    chk("t4_next_rsp_count", rsp_cnt - r0, 2);
    chk("t4_next_err", last_err, 0);
    chk("t4_next_addr", log_a[log_a.size()-1], 32'h4000_0008);

    // 5: slave error response
    cfg(0, 0, 1, 2'b10, 0);
    push(32'h4000_000C, 32'h0000_0003);
    wait_idle();
    chk("t5_rsp_err", last_err, 1);
    chk("t5_rsp_timeout", last_tmo, 0);

    // 6: wready/bvalid held high early must not shortcut the sequence
    cfg(2, 0, 0, 2'b00, 1);
    push(32'h4000_0010, 32'h0000_0004); t0 = acc_cyc;
    wait_idle();
    chk("t6_rsp_cycle", rsp_cyc, t0 + 7);
    chk("t6_rsp_err", last_err, 0);

    // 7: reset while in the data phase with two commands queued
    cfg(0, 1000, 0, 2'b00, 0);
    @(posedge aclk); #1;
    push(32'h4000_0020, 32'h0000_0020);
    push(32'h4000_0024, 32'h0000_0024);
    push(32'h4000_0028, 32'h0000_0028);
    begin
      int n = 0;
      forever begin
        @(negedge aclk);
        if (m_axi.wvalid) break;
        n++;
        if (n > 50) begin
          checks++; fails++;
          $display("FAIL t7_wait_wvalid: wvalid 0, expected 1 within 50 cycles");
          break;
        end
      end
    end
    r0 = rsp_cnt; l0 = log_a.size();
    #2 aresetn = 0;
    #1;
    chk("t7_async_awvalid", m_axi.awvalid, 0);
    chk("t7_async_wvalid", m_axi.wvalid, 0);
    chk("t7_async_bready", m_axi.bready, 0);
    repeat (3) @(posedge aclk);
    #3 aresetn = 1;
    cfg(0, 0, 0, 2'b00, 0);
    repeat (30) @(posedge aclk);
    #1;
    chk("t7_no_rsp", rsp_cnt - r0, 0);
    chk("t7_no_writes", log_a.size() - l0, 0);
    chk("t7_busy", busy, 0);
    push(32'h4000_0030, 32'h0000_0030);
    wait_idle();
    chk("t7_after_rsp", rsp_cnt - r0, 1);
    chk("t7_after_addr", log_a[log_a.size()-1], 32'h4000_0030);
    chk("t7_after_writes", log_a.size() - l0, 1);

    repeat (3) @(posedge aclk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
